// File: rtl/uart_pkg.sv
// Shared UART packet definitions: FSM states, default SOF marker, error codes
// (also used by the Tx-side framer) and a saturating counter helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CHK, HOLD} state_t;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CHKSUM  = 3'd1;
   localparam logic [2:0] ERR_LEN     = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_OVERRUN = 3'd4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, one write port, one combinational read port.
module uart_pkt_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Rx packet controller: frames SOF/CMD/LEN/payload/CHK from UART byte strobes and holds
// good packets for a valid/ready consumer. Optional counters under UART_PKT_STATS_EN.
module uart_rx_pkt_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
   parameter int         TIMEOUT_CYC = 100000,
   localparam int        AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_byte,
   input  logic          rx_done,
   output logic          pkt_valid,
   input  logic          pkt_ready,
   output logic [7:0]    pkt_cmd,
   output logic [AW:0]   pkt_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          err_chksum,
   output logic          err_len,
   output logic          err_timeout,
   output logic          err_overrun
`ifdef UART_PKT_STATS_EN
   ,
   input  logic          stat_clr,
   output logic [7:0]    stat_good,
   output logic [7:0]    stat_chk_err,
   output logic [7:0]    stat_tmo_err
`endif
);

   localparam int            TW       = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    chk_q, chk_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0]    err_q, err_d;

   logic in_frame, tmo_hit, last_byte, len_bad;

   assign in_frame  = (state_q == CMD) || (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
   assign tmo_hit   = in_frame && (tmo_q == TMO_LAST) && !rx_done;
   assign last_byte = ({1'b0, idx_q} == len_q - {{AW{1'b0}}, 1'b1});
   assign len_bad   = int'(rx_byte) > MAX_LEN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         chk_q   <= '0;
         tmo_q   <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         chk_q   <= chk_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   // An rx_done in the timeout cycle suppresses tmo_hit, so the byte wins.
   always_comb begin
      state_d = state_q;
      err_d   = ERR_NONE;
      unique case (state_q)
         IDLE: if (rx_done && rx_byte == SOF_BYTE) state_d = CMD;
         CMD:  if (rx_done) state_d = LEN;
         LEN: if (rx_done) begin
            if (len_bad) begin
               state_d = IDLE;
               err_d   = ERR_LEN;
            end else begin
               state_d = (rx_byte == 8'd0) ? CHK : DATA;
            end
         end
         DATA: if (rx_done && last_byte) state_d = CHK;
         CHK: if (rx_done) begin
            if (rx_byte == chk_q) state_d = HOLD;
            else begin
               state_d = IDLE;
               err_d   = ERR_CHKSUM;
            end
         end
         HOLD: begin
            if (rx_done)   err_d   = ERR_OVERRUN;
            if (pkt_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (tmo_hit) begin
         state_d = IDLE;
         err_d   = ERR_TIMEOUT;
      end
   end

   always_comb begin
      cmd_d = cmd_q;
      len_d = len_q;
      idx_d = idx_q;
      chk_d = chk_q;
      tmo_d = (!in_frame || rx_done || tmo_hit) ? '0 : tmo_q + 1'b1;
      if (rx_done) begin
         unique case (state_q)
            CMD: begin
               cmd_d = rx_byte;
               chk_d = rx_byte;
            end
            LEN: if (!len_bad) begin
               len_d = (AW+1)'(rx_byte);
               chk_d = chk_q ^ rx_byte;
               idx_d = '0;
            end
            DATA: begin
               chk_d = chk_q ^ rx_byte;
               idx_d = idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pkt_valid   = (state_q == HOLD);
      pkt_cmd     = cmd_q;
      pkt_len     = len_q;
      err_chksum  = (err_q == ERR_CHKSUM);
      err_len     = (err_q == ERR_LEN);
      err_timeout = (err_q == ERR_TIMEOUT);
      err_overrun = (err_q == ERR_OVERRUN);
   end

   uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
      .clk     (clk),
      .we_i    ((state_q == DATA) && rx_done),
      .waddr_i (idx_q),
      .wdata_i (rx_byte),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

`ifdef UART_PKT_STATS_EN
   logic [7:0] good_q, chk_err_q, tmo_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_q    <= '0;
         chk_err_q <= '0;
         tmo_err_q <= '0;
      end else if (stat_clr) begin
         good_q    <= '0;
         chk_err_q <= '0;
         tmo_err_q <= '0;
      end else begin
         if (state_d == HOLD && state_q != HOLD) good_q <= sat_inc8(good_q);
         if (err_chksum)  chk_err_q <= sat_inc8(chk_err_q);
         if (err_timeout) tmo_err_q <= sat_inc8(tmo_err_q);
      end
   end

   assign stat_good    = good_q;
   assign stat_chk_err = chk_err_q;
   assign stat_tmo_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl (MAX_LEN=16, TIMEOUT_CYC=20); stats checked when
// UART_PKT_STATS_EN is defined.
module tb_uart_rx_pkt_ctrl;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 20;
   localparam int AW      = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_byte;
   logic          rx_done;
   logic          pkt_valid;
   logic          pkt_ready;
   logic [7:0]    pkt_cmd;
   logic [AW:0]   pkt_len;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          err_chksum, err_len, err_timeout, err_overrun;
`ifdef UART_PKT_STATS_EN
   logic          stat_clr;
   logic [7:0]    stat_good, stat_chk_err, stat_tmo_err;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

   always #5 clk = ~clk;

   uart_rx_pkt_ctrl #(.MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_byte     (rx_byte),
      .rx_done     (rx_done),
      .pkt_valid   (pkt_valid),
      .pkt_ready   (pkt_ready),
      .pkt_cmd     (pkt_cmd),
      .pkt_len     (pkt_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .err_chksum  (err_chksum),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
`ifdef UART_PKT_STATS_EN
      ,
      .stat_clr     (stat_clr),
      .stat_good    (stat_good),
      .stat_chk_err (stat_chk_err),
      .stat_tmo_err (stat_tmo_err)
`endif
   );

   // Pulse counters: sampled at posedge so each cycle of a pulse counts once.
   always @(posedge clk) begin
      if (err_chksum)  n_chk++;
      if (err_len)     n_len++;
      if (err_timeout) n_tmo++;
      if (err_overrun) n_ovr++;
   end

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic release_pkt();
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({pkt_valid, pkt_cmd, pkt_len, err_chksum, err_len, err_timeout, err_overrun} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got valid=%b cmd=%h len=%0d errs=%b%b%b%b, want all 0",
                  pkt_valid, pkt_cmd, pkt_len, err_chksum, err_len, err_timeout, err_overrun);
      end
`ifdef UART_PKT_STATS_EN
      n_cmp++;
      if ({stat_good, stat_chk_err, stat_tmo_err} !== 24'h0) begin
         n_err++;
         $display("FAIL reset_stats: got %h %h %h, want 0", stat_good, stat_chk_err, stat_tmo_err);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release_valid: got %b want 0", pkt_valid);
      end
   endtask

   task automatic test_good_frame();
      logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
      int e0;
      e0 = n_chk + n_len + n_tmo + n_ovr;
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      n_cmp++;
      if (pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL good_valid_early: got %b want 0 before CHK", pkt_valid);
      end
      send_byte(8'h13);
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h10 || pkt_len !== 5'd3) begin
         n_err++;
         $display("FAIL good_hdr: got valid=%b cmd=%h len=%0d, want 1 10 3", pkt_valid, pkt_cmd, pkt_len);
      end
      for (int i = 0; i < 3; i++) begin
         rd_addr = AW'(i);
         #1;
         n_cmp++;
         if (rd_data !== exp[i]) begin
            n_err++;
            $display("FAIL good_payload[%0d]: got %h want %h", i, rd_data, exp[i]);
         end
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h10 || pkt_len !== 5'd3) begin
         n_err++;
         $display("FAIL good_hold_stable: got valid=%b cmd=%h len=%0d", pkt_valid, pkt_cmd, pkt_len);
      end
      release_pkt();
      n_cmp++;
      if (pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL good_release: got valid=%b want 0", pkt_valid);
      end
      n_cmp++;
      if (n_chk + n_len + n_tmo + n_ovr !== e0) begin
         n_err++;
         $display("FAIL good_no_errors: got %0d error pulses want 0", n_chk + n_len + n_tmo + n_ovr - e0);
      end
   endtask

   task automatic test_chksum();
      int c0;
      c0 = n_chk;
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h14);
      n_cmp++;
      if (err_chksum !== 1'b1 || pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL chk_err_pulse: got err=%b valid=%b want 1 0", err_chksum, pkt_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (err_chksum !== 1'b0 || n_chk - c0 !== 1) begin
         n_err++;
         $display("FAIL chk_err_width: got err=%b pulses=%0d want 0 1", err_chksum, n_chk - c0);
      end
      send_byte(8'hA5); send_byte(8'h55); send_byte(8'h02);
      send_byte(8'hAA); send_byte(8'h0F); send_byte(8'hF2);
      rd_addr = 4'd1;
      #1;
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h55 || pkt_len !== 5'd2 || rd_data !== 8'h0F) begin
         n_err++;
         $display("FAIL chk_recover: got valid=%b cmd=%h len=%0d rd1=%h want 1 55 2 0f",
                  pkt_valid, pkt_cmd, pkt_len, rd_data);
      end
      release_pkt();
   endtask

   task automatic test_len();
      int l0;
      l0 = n_len;
      send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11);
      n_cmp++;
      if (err_len !== 1'b1) begin
         n_err++;
         $display("FAIL len_err_pulse: got %b want 1", err_len);
      end
      send_byte(8'hA5); send_byte(8'h60); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h1F);
      rd_addr = 4'd0;
      #1;
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_len !== 5'd1 || rd_data !== 8'h7E || n_len - l0 !== 1) begin
         n_err++;
         $display("FAIL len_recover: got valid=%b len=%0d rd0=%h pulses=%0d want 1 1 7e 1",
                  pkt_valid, pkt_len, rd_data, n_len - l0);
      end
      release_pkt();
      // LEN == MAX_LEN is legal: payload 80..8F XORs to 0, so CHK = 70^10 = 60.
      send_byte(8'hA5); send_byte(8'h70); send_byte(8'h10);
      for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
      send_byte(8'h60);
      rd_addr = 4'd15;
      #1;
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_len !== 5'd16 || rd_data !== 8'h8F || n_len - l0 !== 1) begin
         n_err++;
         $display("FAIL len_max: got valid=%b len=%0d rd15=%h want 1 16 8f", pkt_valid, pkt_len, rd_data);
      end
      release_pkt();
   endtask

   task automatic test_timeout();
      int t0, e0;
      t0 = n_tmo;
      send_byte(8'hA5); send_byte(8'h30);
      repeat (TMO - 1) @(negedge clk);
      n_cmp++;
      if (err_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL tmo_early: got %b want 0 after %0d idle cycles", err_timeout, TMO - 1);
      end
      @(negedge clk);
      n_cmp++;
      if (err_timeout !== 1'b1) begin
         n_err++;
         $display("FAIL tmo_fire: got %b want 1 after %0d idle cycles", err_timeout, TMO);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (n_tmo - t0 !== 1) begin
         n_err++;
         $display("FAIL tmo_once: got %0d pulses want 1", n_tmo - t0);
      end
      e0 = n_chk + n_len + n_tmo + n_ovr;
      send_byte(8'h00); send_byte(8'hFF);
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || n_chk + n_len + n_tmo + n_ovr !== e0) begin
         n_err++;
         $display("FAIL tmo_idle_stray: got valid=%b extra pulses=%0d want 0 0",
                  pkt_valid, n_chk + n_len + n_tmo + n_ovr - e0);
      end
      // Byte arriving in the timeout cycle is processed; CHK = 30^01^5A = 6B.
      t0 = n_tmo;
      send_byte(8'hA5); send_byte(8'h30);
      repeat (TMO - 1) @(negedge clk);
      send_byte(8'h01); send_byte(8'h5A); send_byte(8'h6B);
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_cmd !== 8'h30 || n_tmo - t0 !== 0) begin
         n_err++;
         $display("FAIL tmo_race: got valid=%b cmd=%h tmo_pulses=%0d want 1 30 0",
                  pkt_valid, pkt_cmd, n_tmo - t0);
      end
      release_pkt();
   endtask

   task automatic test_zero_len_overrun();
      int o0;
      o0 = n_ovr;
      send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00); send_byte(8'h40);
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_len !== 5'd0 || pkt_cmd !== 8'h40) begin
         n_err++;
         $display("FAIL zero_len: got valid=%b len=%0d cmd=%h want 1 0 40", pkt_valid, pkt_len, pkt_cmd);
      end
      send_byte(8'h99);
      n_cmp++;
      if (err_overrun !== 1'b1 || pkt_valid !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_hold: got ovr=%b valid=%b want 1 1", err_overrun, pkt_valid);
      end
      pkt_ready = 1'b1;
      send_byte(8'hA5);
      pkt_ready = 1'b0;
      n_cmp++;
      if (err_overrun !== 1'b1 || pkt_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_ready: got ovr=%b valid=%b want 1 0", err_overrun, pkt_valid);
      end
      // If the dropped SOF had been taken, 40 00 40 would complete a packet.
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h40);
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || n_ovr - o0 !== 2) begin
         n_err++;
         $display("FAIL ovr_sof_lost: got valid=%b ovr_pulses=%0d want 0 2", pkt_valid, n_ovr - o0);
      end
   endtask

   task automatic test_reset_mid();
      int e0;
`ifdef UART_PKT_STATS_EN
      n_cmp++;
      if (stat_good !== 8'd6 || stat_chk_err !== 8'd1 || stat_tmo_err !== 8'd1) begin
         n_err++;
         $display("FAIL stats_count: got good=%0d chk=%0d tmo=%0d want 6 1 1",
                  stat_good, stat_chk_err, stat_tmo_err);
      end
`endif
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (pkt_valid !== 1'b0 || pkt_cmd !== 8'h00 || pkt_len !== 5'd0) begin
         n_err++;
         $display("FAIL mid_reset: got valid=%b cmd=%h len=%0d want 0 00 0", pkt_valid, pkt_cmd, pkt_len);
      end
      rst_n = 1'b1;
      @(negedge clk);
      e0 = n_chk + n_len + n_tmo + n_ovr;
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
      rd_addr = 4'd2;
      #1;
      n_cmp++;
      if (pkt_valid !== 1'b1 || pkt_len !== 5'd3 || rd_data !== 8'h33 ||
          n_chk + n_len + n_tmo + n_ovr !== e0) begin
         n_err++;
         $display("FAIL mid_reset_recover: got valid=%b len=%0d rd2=%h pulses=%0d want 1 3 33 0",
                  pkt_valid, pkt_len, rd_data, n_chk + n_len + n_tmo + n_ovr - e0);
      end
`ifdef UART_PKT_STATS_EN
      n_cmp++;
      if (stat_good !== 8'd1) begin
         n_err++;
         $display("FAIL stats_after_reset: got good=%0d want 1", stat_good);
      end
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      n_cmp++;
      if (stat_good !== 8'd0) begin
         n_err++;
         $display("FAIL stats_clr: got good=%0d want 0", stat_good);
      end
`endif
      release_pkt();
   endtask

   initial begin
      rst_n     = 1'b0;
      rx_byte   = 8'h00;
      rx_done   = 1'b0;
      pkt_ready = 1'b0;
      rd_addr   = '0;
`ifdef UART_PKT_STATS_EN
      stat_clr  = 1'b0;
`endif
      test_reset();
      test_good_frame();
      test_chksum();
      test_len();
      test_timeout();
      test_zero_len_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
